// File: rtl/td_rf_seq.sv
// rtl/td_rf_seq.sv - command sequencer driving the time-domain register file strobes
module td_rf_seq #(
    parameter int PW_W   = 8,
    parameter int SETUP  = 1,
    parameter int HOLD   = 1,
    parameter int RD_MAX = 255,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [2:0]       cmd_waddr,
    input  logic [2:0]       cmd_ra,
    input  logic [2:0]       cmd_rb,
    input  logic [PW_W-1:0]  cmd_pw,
    output logic             we,
    output logic             fb,
    output logic             re,
    output logic             w0,
    output logic             w1,
    output logic             w2,
    output logic             ra0,
    output logic             ra1,
    output logic             ra2,
    output logic             rb0,
    output logic             rb1,
    output logic             rb2,
    output logic             rf_rstb,
    input  logic             a,
    input  logic             b,
    output logic             done,
    output logic             rsp_valid,
    output logic [CNT_W-1:0] a_cnt,
    output logic [CNT_W-1:0] b_cnt,
    output logic             a_hit,
    output logic             b_hit
);

    localparam logic [1:0] OP_WRITE    = 2'b00;
    localparam logic [1:0] OP_WRITE_FB = 2'b01;
    localparam logic [1:0] OP_READ     = 2'b10;
    localparam logic [1:0] OP_CLEAR    = 2'b11;

    // One shared phase counter serves SETUP, PULSE, READ, HOLD and CLEAR,
    // so it must be wide enough for the largest of them.
    localparam int SETUP_W = $clog2(SETUP + 1);
    localparam int HOLD_W  = $clog2(HOLD + 1);
    localparam int CW_A    = (PW_W > CNT_W) ? PW_W : CNT_W;
    localparam int CW_B    = (SETUP_W > HOLD_W) ? SETUP_W : HOLD_W;
    localparam int CW_C    = (CW_A > CW_B) ? CW_A : CW_B;
    localparam int CW      = (CW_C > 2) ? CW_C : 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_PULSE,
        S_HOLD,
        S_READ,
        S_CLEAR
    } state_t;

    state_t          state;
    state_t          state_n;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_n;

    logic [1:0]      op_q;
    logic [PW_W-1:0] pw_q;
    logic [2:0]      waddr_q;
    logic [2:0]      ra_q;
    logic [2:0]      rb_q;

    logic            a_s1;
    logic            a_s2;
    logic            b_s1;
    logic            b_s2;

    logic            accept;
    logic            setup_last;
    logic            pulse_last;
    logic            hold_last;
    logic            clear_last;
    logic            rd_timeout;
    logic            rd_both;

    logic            cmd_ready_d;
    logic            we_d;
    logic            fb_d;
    logic            re_d;
    logic            done_d;
    logic            rsp_valid_d;
    logic            rf_rstb_d;

    assign accept     = cmd_valid & cmd_ready;
    assign setup_last = (cnt == CW'(SETUP - 1));
    // A zero pulse width is stretched to a single cycle.
    assign pulse_last = (pw_q == '0) || (cnt == CW'(pw_q - PW_W'(1)));
    assign hold_last  = (cnt == CW'(HOLD - 1));
    // CLEAR spends two cycles with rf_rstb low and a third signalling done.
    assign clear_last = (cnt == CW'(2));
    assign rd_timeout = (cnt == CW'(RD_MAX - 1));
    // Counts a hit landing this very cycle, so READ ends without an idle cycle.
    assign rd_both    = (a_hit | a_s2) & (b_hit | b_s2);

    // State register and shared phase counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // Next-state and phase-counter logic
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:  if (accept) state_n = (cmd_op == OP_CLEAR) ? S_CLEAR : S_SETUP;
            S_SETUP: if (setup_last) state_n = (op_q == OP_READ) ? S_READ : S_PULSE;
            S_PULSE: if (pulse_last) state_n = S_HOLD;
            S_READ:  if (rd_both || rd_timeout) state_n = S_HOLD;
            S_HOLD:  if (hold_last) state_n = S_IDLE;
            S_CLEAR: if (clear_last) state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
        cnt_n = ((state_n != state) || (state == S_IDLE)) ? '0 : cnt + CW'(1);
    end

    // Output decode from the upcoming state so every strobe leaves a flop
    always_comb begin
        cmd_ready_d = (state_n == S_IDLE);
        we_d        = (state_n == S_PULSE) && (op_q == OP_WRITE);
        fb_d        = (state_n == S_PULSE) && (op_q == OP_WRITE_FB);
        re_d        = (state_n == S_READ);
        done_d      = ((state_n == S_HOLD) && (cnt_n == CW'(HOLD - 1)))
                   || ((state_n == S_CLEAR) && (cnt_n == CW'(2)));
        rsp_valid_d = (state == S_READ) && (state_n == S_HOLD);
        rf_rstb_d   = !((state_n == S_CLEAR) && (cnt_n < CW'(2)));
    end

    // Registered strobes; reset drops them and holds the register file in reset
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_ready <= 1'b0;
            we        <= 1'b0;
            fb        <= 1'b0;
            re        <= 1'b0;
            done      <= 1'b0;
            rsp_valid <= 1'b0;
            rf_rstb   <= 1'b0;
        end else begin
            cmd_ready <= cmd_ready_d;
            we        <= we_d;
            fb        <= fb_d;
            re        <= re_d;
            done      <= done_d;
            rsp_valid <= rsp_valid_d;
            rf_rstb   <= rf_rstb_d;
        end
    end

    // Operand capture at accept; addresses stay put until the next command of their kind
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q    <= OP_WRITE;
            pw_q    <= '0;
            waddr_q <= '0;
            ra_q    <= '0;
            rb_q    <= '0;
        end else if (accept) begin
            op_q <= cmd_op;
            pw_q <= cmd_pw;
            if ((cmd_op == OP_WRITE) || (cmd_op == OP_WRITE_FB)) begin
                waddr_q <= cmd_waddr;
            end
            if (cmd_op == OP_READ) begin
                ra_q <= cmd_ra;
                rb_q <= cmd_rb;
            end
        end
    end

    // Two-flop synchronizers, flushed outside READ so a level already high
    // at window start is reported after the two-cycle fill
    always_ff @(posedge clk) begin
        if (rst || (state != S_READ)) begin
            a_s1 <= 1'b0;
            a_s2 <= 1'b0;
            b_s1 <= 1'b0;
            b_s2 <= 1'b0;
        end else begin
            a_s1 <= a;
            a_s2 <= a_s1;
            b_s1 <= b;
            b_s2 <= b_s1;
        end
    end

    // Arrival capture: first synchronized high latches the window counter
    always_ff @(posedge clk) begin
        if (rst) begin
            a_cnt <= '0;
            b_cnt <= '0;
            a_hit <= 1'b0;
            b_hit <= 1'b0;
        end else if (accept && (cmd_op == OP_READ)) begin
            a_hit <= 1'b0;
            b_hit <= 1'b0;
        end else if (state == S_READ) begin
            if (a_s2 && !a_hit) begin
                a_cnt <= CNT_W'(cnt);
                a_hit <= 1'b1;
            end else if (rd_timeout && !a_hit) begin
                a_cnt <= CNT_W'(RD_MAX);
            end
            if (b_s2 && !b_hit) begin
                b_cnt <= CNT_W'(cnt);
                b_hit <= 1'b1;
            end else if (rd_timeout && !b_hit) begin
                b_cnt <= CNT_W'(RD_MAX);
            end
        end
    end

    assign w0  = waddr_q[0];
    assign w1  = waddr_q[1];
    assign w2  = waddr_q[2];
    assign ra0 = ra_q[0];
    assign ra1 = ra_q[1];
    assign ra2 = ra_q[2];
    assign rb0 = rb_q[0];
    assign rb1 = rb_q[1];
    assign rb2 = rb_q[2];

endmodule

// File: doc/td_rf_seq.md
# td_rf_seq

Command sequencer that sits directly upstream of the time-domain register file and drives all of its strobes: write-enable and feedback pulses, read-enable, the write and read address selects, and the active-low register reset. It accepts one command at a time over a valid/ready handshake and converts a digital pulse-width operand into a write strobe of exactly that many cycles. For reads it also samples the file's `a`/`b` outputs and reports, in cycles, when each one first rose.

## Interface
Parameters:
- `PW_W`, 8: width of the pulse-width operand and its counter.
- `SETUP`, 1: cycles the address is held stable before a strobe rises (≥1).
- `HOLD`, 1: cycles the address is held stable after a strobe falls (≥1).
- `RD_MAX`, 255: read window timeout in cycles (≥4, < 2^CNT_W).
- `CNT_W`, 8: width of the read arrival counters.

Ports:
- `clk` in 1: the only clock; all logic is on the rising edge.
- `rst` in 1: synchronous reset, active-high.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: block is idle and can accept a command.
- `cmd_op` in 2: 00 WRITE, 01 WRITE_FB, 10 READ, 11 CLEAR.
- `cmd_waddr` in 3: write register index.
- `cmd_ra` in 3: read port A index.
- `cmd_rb` in 3: read port B index.
- `cmd_pw` in PW_W: write pulse width in cycles.
- `we`, `fb`, `re` out 1 each: strobes to the register file.
- `w0`, `w1`, `w2` out 1 each: write address bits (w2 = MSB).
- `ra0`..`ra2`, `rb0`..`rb2` out 1 each: read address bits.
- `rf_rstb` out 1: active-low register-file reset.
- `a`, `b` in 1 each: register-file outputs, asynchronous to `clk`.
- `done` out 1: one-cycle pulse when a command completes.
- `rsp_valid` out 1: one-cycle pulse when read results are updated.
- `a_cnt`, `b_cnt` out CNT_W: read arrival cycle counts.
- `a_hit`, `b_hit` out 1: the edge was seen inside the read window.

## Operation
- FSM states: IDLE, SETUP, PULSE, HOLD, READ, CLEAR.
- `cmd_ready` is 1 only in IDLE. A command is accepted on the cycle where `cmd_valid` and `cmd_ready` are both 1. All operands are registered at accept; later input changes are ignored.
- **WRITE / WRITE_FB**
  - IDLE → SETUP: the `w*` bits take `cmd_waddr`.
  - SETUP → PULSE after SETUP cycles.
  - In PULSE, `we` (WRITE) or `fb` (WRITE_FB) is high for exactly max(`cmd_pw`,1) cycles. `cmd_pw` = 0 is treated as 1.
  - PULSE → HOLD: the strobe is low and the address is unchanged for HOLD cycles.
  - HOLD → IDLE, with `done` = 1 on the last HOLD cycle.
- **READ**
  - IDLE → SETUP: the `ra*`/`rb*` bits take `cmd_ra`/`cmd_rb`.
  - SETUP → READ: `re` is high. A cycle counter starts at 0 on the first `re`-high cycle.
  - `a` and `b` each pass through a 2-flop synchronizer. The first cycle a synchronized input is seen high latches the counter into `a_cnt`/`b_cnt` and sets `a_hit`/`b_hit`.
  - READ exits when both hits are set, or when the counter reaches RD_MAX−1. On timeout, each missing count is set to RD_MAX and its hit bit stays 0.
  - READ → HOLD: `re` is low, addresses are held. `rsp_valid` pulses on the first HOLD cycle and `done` on the last.
  - Synchronizer latency (2 cycles) is not subtracted from the counts.
- **CLEAR**: `rf_rstb` is low for 2 cycles, then `done` pulses and the FSM returns to IDLE.
- Result registers (`a_cnt`, `b_cnt`, `a_hit`, `b_hit`) hold their values until the next READ enters SETUP. At that point the hit bits clear to 0.
- At most one strobe among `we`, `fb`, `re` is ever high. No address bit changes while any strobe is high.

## Timing
- Reset values:
  - `cmd_ready` = 0 while `rst` is high, 1 on the first cycle after.
  - All strobes, address bits, `done`, `rsp_valid`, counts and hit bits = 0.
  - `rf_rstb` = 0 during reset and 1 one cycle after `rst` deasserts.
- Write latency, accept to `done`: SETUP + max(pw,1) + HOLD cycles. With defaults and pw = 5 this is 7 cycles. The next accept can happen on the cycle after `done`.
- Read latency: SETUP + (cycles in READ) + HOLD. The READ window is at most RD_MAX cycles.
- `a` already high at the start of READ: the count is 2, caused by synchronizer fill. A glitch shorter than one cycle may be missed; this is acceptable.
- `rst` asserted mid-command aborts it on that edge:
  - Strobes drop next cycle.
  - `rf_rstb` goes low.
  - No `done` pulse is produced.
- All outputs are registered; none is driven combinationally from inputs.

## Test plan
- Reset, then WRITE waddr = 5, pw = 3:
  - `w2..w0` = 101 from accept+1.
  - `we` high for exactly 3 cycles starting at accept+2.
  - `done` at accept+5; `fb` stays 0.
- WRITE_FB waddr = 2, pw = 0 → `fb` high for exactly 1 cycle, `we` = 0, address 010 stable across SETUP/PULSE/HOLD.
- READ ra = 3, rb = 6, with `a` driven high 10 cycles and `b` 20 cycles after `re` rises → `a_cnt` = 12, `b_cnt` = 22, both hits = 1, `rsp_valid` pulses once.
- READ with `b` never rising, RD_MAX = 255 → `re` high 255 cycles, `b_cnt` = 255, `b_hit` = 0, `a` result correct.
- CLEAR, then `rst` pulsed during the PULSE state of a WRITE with pw = 50 → `rf_rstb` low for 2 cycles then `done`. After the reset pulse: `we` = 0 next cycle, no `done`, `cmd_ready` = 1 after reset.
- Back-to-back commands with `cmd_valid` held high → each accept occurs one cycle after the previous `done`; operand changes mid-command have no effect.
